// File: rtl/ssm2603_cfg_seq.sv
`timescale 1ns/1ps
// SSM2603 power-up register loader: writes an 8-entry table over open-drain I2C, then enables playback.
// Build option `NACK_RETRY_EN: a NACKed entry is retried up to 3 times before the sequence errors out.
module ssm2603_cfg_seq #(
  parameter int unsigned CLK_DIV   = 184,
  parameter logic [6:0]  DEV_ADDR  = 7'h1A,
  parameter int unsigned DELAY_CYC = 73728,
  parameter int unsigned NUM_REGS  = 8
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_start,
  input  logic in_sda,
  output logic out_scl_oe,
  output logic out_sda_oe,
  output logic out_busy,
  output logic out_done,
  output logic out_err,
  output logic out_codec_en
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned WAIT_W = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ACK1, S_HI, S_ACK2, S_LO, S_ACK3,
    S_STOP, S_GAP, S_WAIT, S_FIN, S_ERR
  } state_t;

  state_t            state, state_n;
  logic [DIV_W-1:0]  div_cnt;
  logic [1:0]        phase;
  logic [2:0]        bit_cnt;
  logic [2:0]        idx;
  logic [WAIT_W-1:0] wait_cnt;
  logic              nack;
  logic              sda_meta, sda_s;
  logic              scl_c, sda_c;
  logic              q_end, slot_end, last_idx, can_retry;
  logic [15:0]       word;
  logic [7:0]        tx_byte;

  function automatic logic [15:0] reg_word(input logic [2:0] i);
    case (i)
      3'd0:    reg_word = 16'h1E00;
      3'd1:    reg_word = 16'h0C72;
      3'd2:    reg_word = 16'h0810;
      3'd3:    reg_word = 16'h0A00;
      3'd4:    reg_word = 16'h0E09;
      3'd5:    reg_word = 16'h1000;
      3'd6:    reg_word = 16'h1201;
      default: reg_word = 16'h0C62;
    endcase
  endfunction

  assign q_end    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign slot_end = q_end && (phase == 2'd3);
  assign last_idx = (idx == 3'(NUM_REGS - 1));

`ifdef NACK_RETRY_EN
  logic [1:0] retry_cnt;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst)
      retry_cnt <= '0;
    else if (state == S_IDLE)
      retry_cnt <= '0;
    else if (state == S_GAP && slot_end)
      retry_cnt <= nack ? retry_cnt + 2'd1 : 2'd0;
  end

  always_comb can_retry = (retry_cnt != 2'd3);
`else
  always_comb can_retry = 1'b0;
`endif

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    scl_c   = 1'b0;
    sda_c   = 1'b0;
    word    = reg_word(idx);
    case (state)
      S_ADDR:  tx_byte = {DEV_ADDR, 1'b0};
      S_HI:    tx_byte = word[15:8];
      default: tx_byte = word[7:0];
    endcase

    case (state)
      S_IDLE: if (in_start) state_n = S_START;
      // SDA falls in phase 1 with SCL still released; SCL is pulled from phase 2 on.
      S_START: begin
        scl_c = (phase >= 2'd2);
        sda_c = (phase >= 2'd1);
        if (slot_end) state_n = S_ADDR;
      end
      S_ADDR, S_HI, S_LO: begin
        scl_c = (phase == 2'd0) || (phase == 2'd3);
        sda_c = ~tx_byte[3'd7 - bit_cnt];
        if (slot_end && bit_cnt == 3'd7) begin
          case (state)
            S_ADDR:  state_n = S_ACK1;
            S_HI:    state_n = S_ACK2;
            default: state_n = S_ACK3;
          endcase
        end
      end
      S_ACK1, S_ACK2, S_ACK3: begin
        scl_c = (phase == 2'd0) || (phase == 2'd3);
        if (slot_end) begin
          if (nack)                state_n = S_STOP;
          else if (state == S_ACK1) state_n = S_HI;
          else if (state == S_ACK2) state_n = S_LO;
          else                      state_n = S_STOP;
        end
      end
      // SDA held low through the SCL rise, released in phase 2.
      S_STOP: begin
        scl_c = (phase == 2'd0);
        sda_c = (phase <= 2'd1);
        if (slot_end) state_n = (nack && !can_retry) ? S_ERR : S_GAP;
      end
      S_GAP: begin
        if (slot_end) begin
          if (nack)                 state_n = S_START;
          else if (last_idx)        state_n = S_FIN;
          else if (idx == 3'd5)     state_n = S_WAIT;
          else                      state_n = S_START;
        end
      end
      S_WAIT: if (wait_cnt == WAIT_W'(DELAY_CYC - 1)) state_n = S_START;
      S_FIN:   state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      div_cnt      <= '0;
      phase        <= '0;
      bit_cnt      <= '0;
      idx          <= '0;
      wait_cnt     <= '0;
      nack         <= 1'b0;
      sda_meta     <= 1'b1;
      sda_s        <= 1'b1;
      out_scl_oe   <= 1'b0;
      out_sda_oe   <= 1'b0;
      out_busy     <= 1'b0;
      out_done     <= 1'b0;
      out_err      <= 1'b0;
      out_codec_en <= 1'b0;
    end else begin
      out_scl_oe <= scl_c;
      out_sda_oe <= sda_c;
      sda_meta   <= in_sda;
      sda_s      <= sda_meta;

      if (state_n != state) begin
        div_cnt <= '0;
        phase   <= '0;
        bit_cnt <= '0;
      end else if (q_end) begin
        div_cnt <= '0;
        phase   <= phase + 2'd1;
        if (phase == 2'd3) bit_cnt <= bit_cnt + 3'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      wait_cnt <= (state == S_WAIT) ? wait_cnt + WAIT_W'(1) : '0;

      if (state_n == S_START && state != S_START)
        nack <= 1'b0;
      else if ((state == S_ACK1 || state == S_ACK2 || state == S_ACK3) &&
               q_end && phase == 2'd1 && sda_s)
        nack <= 1'b1;

      if (state == S_IDLE && in_start) begin
        out_busy     <= 1'b1;
        out_done     <= 1'b0;
        out_err      <= 1'b0;
        out_codec_en <= 1'b0;
        idx          <= '0;
      end

      if (state == S_GAP && slot_end && !nack && !last_idx)
        idx <= idx + 3'd1;

      if (state == S_FIN) begin
        out_busy     <= 1'b0;
        out_done     <= 1'b1;
        out_codec_en <= 1'b1;
      end

      if (state == S_ERR) begin
        out_busy <= 1'b0;
        out_err  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ssm2603_cfg_seq.md
Name: ssm2603_cfg_seq

Overview:
Power-up configuration sequencer for the SSM2603 audio codec that sits next to the i2s playback transmitter. After in_start it writes a fixed register table to the codec over a single-master I2C bus, using open-drain SCL/SDA enables. It then asserts out_codec_en, which gates the transmitter's in_en so playback starts only on a configured codec. It reports NACKs, and a new in_start reruns the whole sequence.

Parameters:
CLK_DIV, 184, in_clk cycles per quarter SCL period; 73.728 MHz/(4*184) gives about 100.2 kHz
DEV_ADDR, 7'h1A, codec 7-bit I2C address; write byte = {DEV_ADDR,1'b0} = 8'h34
DELAY_CYC, 73728, in_clk cycles waited after table entry 5 before entry 6; 1 ms at 73.728 MHz
NUM_REGS, 8, table entries

Ports:
in_clk  input  1  system clock, 73.728 MHz
in_rst  input  1  reset, asynchronous, active-high
in_start  input  1  single-cycle pulse; starts the sequence; ignored while out_busy=1
in_sda  input  1  sampled SDA line, synchronised internally with 2 flops
out_scl_oe  output  1  1 = pull SCL low, 0 = release
out_sda_oe  output  1  1 = pull SDA low, 0 = release
out_busy  output  1  sequence in progress
out_done  output  1  sticky; whole table ACKed; cleared by in_start
out_err  output  1  sticky; a NACK occurred; cleared by in_start
out_codec_en  output  1  high after out_done; low during busy, after reset and after an error

Behaviour:
- Reset: clock and reset are as stated under the interface above (one clock in_clk; in_rst asynchronous, active-high). All outputs go to 0, so the bus is released, the state is IDLE and the table index is 0. A reset mid-transfer releases both lines immediately; a truncated transfer is acceptable.
- Register table, index: 16-bit word {reg[6:0],data[8:0]}, sent MSB byte first:
  - 0: R15=0x000 (16'h1E00)
  - 1: R6=0x072 (16'h0C72)
  - 2: R4=0x010 (16'h0810)
  - 3: R5=0x000 (16'h0A00)
  - 4: R7=0x009, left-justified, 24-bit (16'h0E09)
  - 5: R8=0x000 (16'h1000)
  - 6: R9=0x001, active (16'h1201)
  - 7: R6=0x062, output powered (16'h0C62)
- Bit timing: each bit takes 4 phases of CLK_DIV cycles.
  - Phase 0: SCL low, SDA changes.
  - Phases 1-2: SCL released.
  - Phase 3: SCL low.
  - ACK is sampled from synchronised SDA at the end of phase 1.
- FSM: IDLE -> START -> ADDR(8 bits) -> ACK1 -> BYTE_HI(8) -> ACK2 -> BYTE_LO(8) -> ACK3 -> STOP -> GAP -> (next entry: START | WAIT | FIN) and ERR.
  - START: SDA falls while SCL is high; one quarter period each side.
  - STOP: SDA rises while SCL is high.
  - GAP: 4*CLK_DIV cycles of bus-free time.
  - WAIT: DELAY_CYC cycles, entered only after index 5.
  - FIN: sets out_done and out_codec_en, clears out_busy, returns to IDLE.
- NACK (SDA=1 at any ACK sample): go to STOP, then ERR. ERR sets out_err, clears out_busy, leaves out_codec_en=0 and returns to IDLE.
- in_start accepted in IDLE:
  - Clears out_done, out_err and out_codec_en in the next cycle.
  - Sets out_busy the same cycle.
  - Index returns to 0.
- in_start coinciding with in_rst: reset wins.
- Nominal frame length: 29 bit-slots (START + 27 data/ACK bits + STOP) plus GAP. The SDA driver never changes while SCL is released, except in START and STOP.

Optional Feature:
NACK_RETRY_EN
- Defined: a NACK on an entry triggers STOP and GAP, then a retry of the same entry, up to 3 retries (4 attempts total). The retry count resets per entry. Only the 4th NACK leads to ERR.
- Undefined: the first NACK leads to ERR, as above.

Test Plan:
1. Reset release, in_start pulse, I2C slave model ACKing everything -> 8 frames decoded as 34 1E 00, 34 0C 72, 34 08 10, 34 0A 00, 34 0E 09, 34 10 00, 34 12 01, 34 0C 62. Then out_done=1, out_codec_en=1, out_busy=0.
2. Measure SCL -> high time = 2*184 cycles, period 736 cycles. Gap between the 6th STOP and the 7th START >= 73728 cycles.
3. Slave NACKs the data byte of entry 4 (macro off) -> STOP follows, out_err=1, out_codec_en=0, no frame 5 on the bus.
4. Same NACK with NACK_RETRY_EN, slave ACKs on the 3rd attempt -> entry 4 is sent 3 times, sequence completes, out_err=0. Slave NACKs 4 times -> out_err=1.
5. in_rst asserted mid-BYTE_HI of entry 2 -> out_scl_oe and out_sda_oe are 0 asynchronously, all flags 0. A later in_start restarts at entry 0.
6. in_start pulses while busy -> ignored, frame sequence unchanged. in_start after done -> out_done drops for a full rerun, then rises again.
